// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle for the BCD countdown timer.
// The master drives load/run control; the slave (the timer) returns the count and status.
interface bcd_countdown_timer_if #(
    parameter int unsigned NUM_DIGITS = 2
);
    logic                    reconfig;
    logic [4*NUM_DIGITS-1:0] load_value;
    logic                    start;
    logic                    pause;
    logic                    tick;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    running;
    logic                    timeout;
    logic                    timeout_pulse;

    modport master (
        output reconfig, load_value, start, pause, tick,
        input  digits, running, timeout, timeout_pulse
    );

    modport slave (
        input  reconfig, load_value, start, pause, tick,
        output digits, running, timeout, timeout_pulse
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with start/pause control, optional auto-reload,
// BCD clamping on load, and level plus pulse timeout outputs. All outputs registered.
module bcd_countdown_timer #(
    parameter int unsigned                NUM_DIGITS  = 2,
    parameter logic [4*NUM_DIGITS-1:0]    INIT_VALUE  = (4*NUM_DIGITS)'(8'h30),
    parameter bit                         AUTO_RELOAD = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    bcd_countdown_timer_if.slave bus
);
    localparam int unsigned Width = 4 * NUM_DIGITS;

    typedef logic [Width-1:0] countT;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StExpired
    } stateT;

    stateT stateQ, stateD;
    countT digitsQ, digitsD;
    logic  runningQ, timeoutQ, pulseQ;
    logic  pulseD;
    countT loadClamped;
    countT decremented;

    // Saturate every nibble above 9 to 9 so a bad load can never leave non-BCD digits.
    function automatic countT clampBcd(input countT v);
        countT r;
        r = v;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Subtract one with a per-digit borrow chain; a zero digit wraps to 9 and borrows.
    function automatic countT decBcd(input countT v);
        countT r;
        logic  borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign loadClamped = clampBcd(bus.load_value);
    assign decremented = decBcd(digitsQ);

    // Next-state and next-output decode; reconfig outranks every control in any state.
    always_comb begin
        stateD  = stateQ;
        digitsD = digitsQ;
        pulseD  = 1'b0;
        if (bus.reconfig) begin
            stateD  = StIdle;
            digitsD = loadClamped;
        end else begin
            unique case (stateQ)
                StIdle, StPaused: begin
                    if (bus.start) begin
                        if (digitsQ == '0) begin
                            stateD = StExpired;
                            pulseD = 1'b1;
                        end else begin
                            stateD = StRun;
                        end
                    end
                end
                StRun: begin
                    if (bus.pause) begin
                        stateD = StPaused;
                    end else if (bus.tick) begin
                        if (decremented == '0) begin
                            pulseD = 1'b1;
                            // A zero reload value would park RUN at zero, so it expires instead.
                            if (AUTO_RELOAD && (loadClamped != '0)) begin
                                digitsD = loadClamped;
                            end else begin
                                digitsD = '0;
                                stateD  = StExpired;
                            end
                        end else begin
                            digitsD = decremented;
                        end
                    end
                end
                StExpired: begin
                    digitsD = '0;
                end
                default: begin
                    stateD = StIdle;
                end
            endcase
        end
    end

    // State and registered outputs; synchronous reset discards count and any pending pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= StIdle;
            digitsQ  <= INIT_VALUE;
            runningQ <= 1'b0;
            timeoutQ <= 1'b0;
            pulseQ   <= 1'b0;
        end else begin
            stateQ   <= stateD;
            digitsQ  <= digitsD;
            runningQ <= (stateD == StRun);
            timeoutQ <= (stateD == StExpired);
            pulseQ   <= pulseD;
        end
    end

    assign bus.digits        = digitsQ;
    assign bus.running       = runningQ;
    assign bus.timeout       = timeoutQ;
    assign bus.timeout_pulse = pulseQ;
endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit BCD countdown timer.
- Successor to the single-digit timer wrapper: the digit count is a parameter, and the block adds start/pause control, an optional auto-reload mode, BCD clamping on load, and both a level and a pulse timeout output.
- Counts down once per qualifying `tick` enable, supplied by the existing one-second prescaler.
- Feeds the access controller (timeout) and the 7-segment decode path (digits).

Parameters:
- NUM_DIGITS, 2, number of BCD digits; legal range 1..6; the count is 4*NUM_DIGITS bits wide.
- INIT_VALUE, 8'h30 (zero-extended to 4*NUM_DIGITS), BCD count loaded by `rst`.
- AUTO_RELOAD, 0, selects what happens on expiry:
  - 0: stop in EXPIRED.
  - 1: reload `load_value` and keep running.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- reconfig  input  1  synchronous load of `load_value`; returns the timer to IDLE.
- load_value  input  4*NUM_DIGITS  BCD reload value; digit 0 is in bits [3:0].
- start  input  1  single-cycle request to begin or resume counting.
- pause  input  1  single-cycle request to hold the count.
- tick  input  1  count enable, one clk wide, nominally 1 Hz.
- digits  output  4*NUM_DIGITS  current BCD count, registered.
- running  output  1  high while in RUN.
- timeout  output  1  level; high while in EXPIRED.
- timeout_pulse  output  1  one clk pulse on every expiry event, including auto-reload expiries.

Behaviour:
- States: IDLE, RUN, PAUSED, EXPIRED. Encoded state register; all outputs registered.
- Reset: `rst` sampled high gives the following on the next edge:
  - digits=INIT_VALUE, state=IDLE.
  - running=0, timeout=0, timeout_pulse=0.
  - `rst` overrides every other input.
- Priority per cycle: rst > reconfig > pause > start > tick.
- Load clamp: when loading, any `load_value` nibble greater than 9 is loaded as 9. The clamp applies only to `load_value` loads; INIT_VALUE must be valid BCD by construction.
- reconfig, in any state:
  - digits=clamped `load_value`, state=IDLE, timeout=0.
  - A `start`, `pause` or `tick` in the same cycle is ignored.
- IDLE or PAUSED with `start`:
  - If digits≠0: go to RUN; running=1 from the next cycle.
  - If digits==0: go to EXPIRED and pulse `timeout_pulse`.
  - A `tick` in the same cycle is ignored; counting begins with the first tick after `start`.
- RUN with `pause`: go to PAUSED; a `tick` in the same cycle is dropped and digits hold.
- `start` while in RUN is ignored. `pause` outside RUN is ignored.
- RUN with `tick`: decrement by 1 in BCD with a borrow chain.
  - Digit i wraps 0→9 and borrows from digit i+1.
  - Digits update on the edge after `tick` is sampled (1-cycle latency).
- Expiry: when a decrement produces all-zero digits:
  - AUTO_RELOAD=0: digits=0, state=EXPIRED, timeout=1 and timeout_pulse=1 on the same edge.
  - AUTO_RELOAD=1: digits=clamped `load_value` instead of 0, state stays RUN, timeout_pulse=1, timeout stays 0.
- EXPIRED: holds digits=0 and timeout=1; `tick`, `start` and `pause` are ignored. Only `reconfig` or `rst` leaves EXPIRED.
- `timeout_pulse` is never high for more than 1 consecutive cycle unless ticks arrive on consecutive clks under AUTO_RELOAD=1 with `load_value`=1.
- Wrap-around below zero never occurs: a RUN state with digits==0 is unreachable.
- Reset mid-count discards the count and any pending pulse.

Test Plan:
- Reset: NUM_DIGITS=2, assert rst for 2 clks → digits=8'h30, running=0, timeout=0, timeout_pulse=0.
- Full countdown:
  - Stimulus: reconfig with load_value=8'h12, start, then 12 ticks spaced 5 clks apart.
  - Required: after tick 2, digits=8'h10; after tick 3, digits=8'h09 (borrow); after tick 12, digits=8'h00 and timeout=1, with timeout_pulse high for exactly 1 clk.
- Pause/resume:
  - Stimulus: load 8'h05, start, 2 ticks (digits=8'h03), then pause with a tick in the same cycle, then 3 more ticks.
  - Required: digits stay 8'h03 while paused; after start plus 1 tick, digits=8'h02.
- Auto-reload: AUTO_RELOAD=1, load 8'h02, start, 6 ticks → timeout_pulse fires after ticks 2, 4 and 6; digits return to 8'h02 each time; timeout stays 0; running stays 1.
- Clamp and zero start:
  - Stimulus 1: reconfig with load_value=8'hA7. Required: digits=8'h97.
  - Stimulus 2: reconfig with 8'h00, then start. Required: EXPIRED next cycle, timeout=1, one timeout_pulse.
- Reconfig/reset mid-run:
  - Stimulus 1: in RUN at 8'h45, reconfig with 8'h20 and a simultaneous tick. Required: digits=8'h20, state IDLE, running=0; later ticks are ignored until start.
  - Stimulus 2: in EXPIRED, assert rst. Required: digits=8'h30, timeout=0.
